// File: rtl/uc_pipe_pkg.sv
// Shared control-unit definitions: opcodes, ALUOp codes and the per-stage control bundles.
// Used by uc_decode and uc_pipe.
package uc_pkg;

    localparam int CTRL_ALUOP_W = 3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_MUL   = 6'b011100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [CTRL_ALUOP_W-1:0] ALU_ADD   = 3'b000;
    localparam logic [CTRL_ALUOP_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [CTRL_ALUOP_W-1:0] ALU_AND   = 3'b010;
    localparam logic [CTRL_ALUOP_W-1:0] ALU_OR    = 3'b011;
    localparam logic [CTRL_ALUOP_W-1:0] ALU_SLT   = 3'b100;
    localparam logic [CTRL_ALUOP_W-1:0] ALU_RTYPE = 3'b101;

    typedef struct packed {
        logic                    reg_dst;
        logic                    alu_src;
        logic                    mem_to_reg;
        logic                    reg_write;
        logic                    mem_read;
        logic                    mem_write;
        logic                    branch;
        logic [CTRL_ALUOP_W-1:0] alu_op;
    } ctrl_t;

    // Later stages only carry the fields they still consume.
    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } mem_ctrl_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } wb_ctrl_t;

    localparam ctrl_t     CTRL_NOP     = '0;
    localparam mem_ctrl_t MEM_CTRL_NOP = '0;
    localparam wb_ctrl_t  WB_CTRL_NOP  = '0;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_MUL, OP_LW, OP_SW, OP_BEQ,
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: op_legal = 1'b1;
            default:                           op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uc_pipe_if.sv
// IF/ID-side inputs and stage control outputs of the pipelined control unit.
// UC_PIPE_ILLEGAL_TRAP_EN adds the ex_illegal / illegal_cnt signals.
interface uc_pipe_if #(
    parameter int RA_W    = 5,
    parameter int ALUOP_W = 3
);
    logic [5:0]         id_op;
    logic               id_valid;
    logic [RA_W-1:0]    id_rs;
    logic [RA_W-1:0]    id_rt;
    logic               mem_branch_taken;
    logic               ex_reg_dst;
    logic               ex_alu_src;
    logic [ALUOP_W-1:0] ex_alu_op;
    logic [RA_W-1:0]    ex_rt;
    logic               mem_branch;
    logic               mem_read;
    logic               mem_write;
    logic               wb_reg_write;
    logic               wb_mem_to_reg;
    logic               pc_write;
    logic               ifid_write;
    logic               ifid_flush;
`ifdef UC_PIPE_ILLEGAL_TRAP_EN
    logic               ex_illegal;
    logic [7:0]         illegal_cnt;

    modport master (
        output id_op, id_valid, id_rs, id_rt, mem_branch_taken,
        input  ex_reg_dst, ex_alu_src, ex_alu_op, ex_rt,
        input  mem_branch, mem_read, mem_write, wb_reg_write, wb_mem_to_reg,
        input  pc_write, ifid_write, ifid_flush, ex_illegal, illegal_cnt
    );
    modport slave (
        input  id_op, id_valid, id_rs, id_rt, mem_branch_taken,
        output ex_reg_dst, ex_alu_src, ex_alu_op, ex_rt,
        output mem_branch, mem_read, mem_write, wb_reg_write, wb_mem_to_reg,
        output pc_write, ifid_write, ifid_flush, ex_illegal, illegal_cnt
    );
`else
    modport master (
        output id_op, id_valid, id_rs, id_rt, mem_branch_taken,
        input  ex_reg_dst, ex_alu_src, ex_alu_op, ex_rt,
        input  mem_branch, mem_read, mem_write, wb_reg_write, wb_mem_to_reg,
        input  pc_write, ifid_write, ifid_flush
    );
    modport slave (
        input  id_op, id_valid, id_rs, id_rt, mem_branch_taken,
        output ex_reg_dst, ex_alu_src, ex_alu_op, ex_rt,
        output mem_branch, mem_read, mem_write, wb_reg_write, wb_mem_to_reg,
        output pc_write, ifid_write, ifid_flush
    );
`endif
endinterface

// File: rtl/uc_pipe_decode.sv
// Combinational ID-stage opcode decoder; unknown opcodes and invalid slots yield CTRL_NOP.
module uc_decode
    import uc_pkg::*;
(
    input  logic [5:0] op,
    input  logic       valid,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = CTRL_NOP;
        if (valid) begin
            case (op)
                OP_RTYPE, OP_MUL: begin
                    ctrl.reg_dst   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALU_RTYPE;
                end
                OP_LW: begin
                    ctrl.alu_src    = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_read   = 1'b1;
                    ctrl.alu_op     = ALU_ADD;
                end
                OP_SW: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.mem_write = 1'b1;
                    ctrl.alu_op    = ALU_ADD;
                end
                OP_BEQ: begin
                    ctrl.branch = 1'b1;
                    ctrl.alu_op = ALU_SUB;
                end
                OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    case (op)
                        OP_ANDI: ctrl.alu_op = ALU_AND;
                        OP_ORI:  ctrl.alu_op = ALU_OR;
                        OP_SLTI: ctrl.alu_op = ALU_SLT;
                        default: ctrl.alu_op = ALU_ADD;
                    endcase
                end
                default: ctrl = CTRL_NOP;
            endcase
        end
    end

endmodule

// File: rtl/uc_pipe.sv
// Pipelined MIPS control unit: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use stall and branch flush. UC_PIPE_ILLEGAL_TRAP_EN adds illegal-opcode flag and counter.
module uc_pipe
    import uc_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int RA_W    = 5
) (
    input logic   clk,
    input logic   rst,
    uc_pipe_if.slave bus
);

    ctrl_t           id_ctrl;
    ctrl_t           idex;
    logic [RA_W-1:0] idex_rt;
    mem_ctrl_t       exmem;
    wb_ctrl_t        memwb;
    logic            stall;
    logic            flush;

    uc_decode u_decode (
        .op    (bus.id_op),
        .valid (bus.id_valid),
        .ctrl  (id_ctrl)
    );

    // Load in EX whose destination is a source of the instruction in ID; $zero never hazards.
    assign flush = bus.mem_branch_taken;
    assign stall = idex.mem_read && (idex_rt != '0) && bus.id_valid &&
                   ((idex_rt == bus.id_rs) || (idex_rt == bus.id_rt));

    assign bus.pc_write   = rst || flush || !stall;
    assign bus.ifid_write = rst || flush || !stall;
    assign bus.ifid_flush = !rst && flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            idex    <= CTRL_NOP;
            idex_rt <= '0;
            exmem   <= MEM_CTRL_NOP;
            memwb   <= WB_CTRL_NOP;
        end else begin
            idex    <= (flush || stall) ? CTRL_NOP : id_ctrl;
            idex_rt <= (flush || stall) ? '0 : bus.id_rt;
            if (flush) begin
                exmem <= MEM_CTRL_NOP;
            end else begin
                exmem.mem_to_reg <= idex.mem_to_reg;
                exmem.reg_write  <= idex.reg_write;
                exmem.mem_read   <= idex.mem_read;
                exmem.mem_write  <= idex.mem_write;
                exmem.branch     <= idex.branch;
            end
            memwb.mem_to_reg <= exmem.mem_to_reg;
            memwb.reg_write  <= exmem.reg_write;
        end
    end

    assign bus.ex_reg_dst    = idex.reg_dst;
    assign bus.ex_alu_src    = idex.alu_src;
    assign bus.ex_alu_op     = ALUOP_W'(idex.alu_op);
    assign bus.ex_rt         = idex_rt;
    assign bus.mem_branch    = exmem.branch;
    assign bus.mem_read      = exmem.mem_read;
    assign bus.mem_write     = exmem.mem_write;
    assign bus.wb_reg_write  = memwb.reg_write;
    assign bus.wb_mem_to_reg = memwb.mem_to_reg;

`ifdef UC_PIPE_ILLEGAL_TRAP_EN
    logic       illegal_next;
    logic       ex_illegal_q;
    logic [7:0] illegal_cnt_q;

    // Bubbles from stall or flush are not instructions, so they never count as illegal.
    assign illegal_next = bus.id_valid && !op_legal(bus.id_op) && !stall && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_illegal_q  <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            ex_illegal_q <= illegal_next;
            if (illegal_next && (illegal_cnt_q != 8'hFF)) begin
                illegal_cnt_q <= illegal_cnt_q + 8'd1;
            end
        end
    end

    assign bus.ex_illegal  = ex_illegal_q;
    assign bus.illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_uc_pipe.sv
// Directed, table-driven bench for uc_pipe; exercises the trap counter when
// UC_PIPE_ILLEGAL_TRAP_EN is defined.
module tb_uc_pipe;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    uc_pipe_if #(.RA_W(5), .ALUOP_W(3)) bus ();

    uc_pipe #(.ALUOP_W(3), .RA_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp bit order: reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op[2:0]
    typedef struct {
        logic [5:0] op;
        logic       valid;
        logic [4:0] rt;
        logic [9:0] exp;
        string      name;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [5:0] op, input logic valid,
                                  input logic [4:0] rs, input logic [4:0] rt);
        bus.id_op    = op;
        bus.id_valid = valid;
        bus.id_rs    = rs;
        bus.id_rt    = rt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.mem_branch_taken = 1'b0;
        apply_stimulus(6'b000000, 1'b0, 5'd0, 5'd0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        apply_stimulus(6'b000000, 1'b0, 5'd0, 5'd0);
        bus.mem_branch_taken = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        logic [2:0] s_alu [5];
        logic       s_mr  [5];
        logic       s_br  [5];
        logic       s_rw  [5];
        logic [5:0] s_op  [5];
        logic [4:0] s_rs  [5];
        logic [4:0] s_rt  [5];
        int         wb_hits;

        total = 0;
        bad   = 0;

        vecs[0]  = '{6'b000000, 1'b1, 5'd1,  10'b1_0_0_1_0_0_0_101, "rtype"};
        vecs[1]  = '{6'b011100, 1'b1, 5'd2,  10'b1_0_0_1_0_0_0_101, "mul"};
        vecs[2]  = '{6'b100011, 1'b1, 5'd3,  10'b0_1_1_1_1_0_0_000, "lw"};
        vecs[3]  = '{6'b101011, 1'b1, 5'd4,  10'b0_1_0_0_0_1_0_000, "sw"};
        vecs[4]  = '{6'b000100, 1'b1, 5'd5,  10'b0_0_0_0_0_0_1_001, "beq"};
        vecs[5]  = '{6'b001000, 1'b1, 5'd6,  10'b0_1_0_1_0_0_0_000, "addi"};
        vecs[6]  = '{6'b001100, 1'b1, 5'd7,  10'b0_1_0_1_0_0_0_010, "andi"};
        vecs[7]  = '{6'b001101, 1'b1, 5'd8,  10'b0_1_0_1_0_0_0_011, "ori"};
        vecs[8]  = '{6'b001010, 1'b1, 5'd9,  10'b0_1_0_1_0_0_0_100, "slti"};
        vecs[9]  = '{6'b111111, 1'b1, 5'd10, 10'b0_0_0_0_0_0_0_000, "illegal"};
        vecs[10] = '{6'b100011, 1'b0, 5'd11, 10'b0_0_0_0_0_0_0_000, "invalid_lw"};

        // Reset held two cycles with a valid LW presented.
        rst = 1'b1;
        bus.mem_branch_taken = 1'b0;
        apply_stimulus(6'b100011, 1'b1, 5'd0, 5'd9);
        tick();
        tick();
        check_output("rst_ex", {bus.ex_reg_dst, bus.ex_alu_src, bus.ex_alu_op}, 5'b0);
        check_output("rst_ex_rt", bus.ex_rt, 5'd0);
        check_output("rst_mem", {bus.mem_branch, bus.mem_read, bus.mem_write}, 3'b0);
        check_output("rst_wb", {bus.wb_reg_write, bus.wb_mem_to_reg}, 2'b0);
        check_output("rst_ctl", {bus.pc_write, bus.ifid_write, bus.ifid_flush}, 3'b110);
        rst = 1'b0;
        tick();
        check_output("first_lw_ex", {bus.ex_reg_dst, bus.ex_alu_src, bus.ex_alu_op}, 5'b0_1_000);
        check_output("first_lw_rt", bus.ex_rt, 5'd9);

        // Reset beats a simultaneous branch flush and kills the LW in flight.
        apply_stimulus(6'b000000, 1'b0, 5'd0, 5'd0);
        rst = 1'b1;
        bus.mem_branch_taken = 1'b1;
        #1;
        check_output("rst_over_flush", {bus.pc_write, bus.ifid_write, bus.ifid_flush}, 3'b110);
        tick();
        check_output("rst_kill_mem", bus.mem_read, 1'b0);
        rst = 1'b0;
        bus.mem_branch_taken = 1'b0;
        drain();

        // Decode table: one instruction followed by bubbles, checked at EX, MEM, WB.
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].valid, 5'd0, vecs[i].rt);
            tick();
            check_output({vecs[i].name, "_ex"},
                         {bus.ex_reg_dst, bus.ex_alu_src, bus.ex_alu_op},
                         {vecs[i].exp[9], vecs[i].exp[8], vecs[i].exp[2:0]});
            if (vecs[i].valid)
                check_output({vecs[i].name, "_ex_rt"}, bus.ex_rt, vecs[i].rt);
            apply_stimulus(6'b000000, 1'b0, 5'd0, 5'd0);
            tick();
            check_output({vecs[i].name, "_mem"},
                         {bus.mem_read, bus.mem_write, bus.mem_branch},
                         vecs[i].exp[5:3]);
            tick();
            check_output({vecs[i].name, "_wb"},
                         {bus.wb_mem_to_reg, bus.wb_reg_write},
                         vecs[i].exp[7:6]);
        end

        // Back-to-back stream ADDI, LW, SW, BEQ, ORI with no hazards.
        s_op  = '{6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b001101};
        s_rs  = '{5'd1, 5'd1, 5'd3, 5'd2, 5'd4};
        s_rt  = '{5'd2, 5'd7, 5'd8, 5'd3, 5'd6};
        s_alu = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b011};
        s_mr  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        s_br  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        s_rw  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            if (i < 5) begin
                apply_stimulus(s_op[i], 1'b1, s_rs[i], s_rt[i]);
                #1;
                check_output($sformatf("stream_pc_write_%0d", i), bus.pc_write, 1'b1);
            end else begin
                apply_stimulus(6'b000000, 1'b0, 5'd0, 5'd0);
            end
            tick();
            if (i < 5)
                check_output($sformatf("stream_ex_alu_op_%0d", i), bus.ex_alu_op, s_alu[i]);
            if (i >= 1 && i <= 5) begin
                check_output($sformatf("stream_mem_read_%0d", i - 1), bus.mem_read, s_mr[i-1]);
                check_output($sformatf("stream_mem_branch_%0d", i - 1), bus.mem_branch, s_br[i-1]);
            end
            if (i >= 2)
                check_output($sformatf("stream_wb_reg_write_%0d", i - 2), bus.wb_reg_write, s_rw[i-2]);
        end
        drain();

        // Load-use: LW rt=5 then R-type rs=5 stalls exactly one cycle.
        apply_stimulus(6'b100011, 1'b1, 5'd1, 5'd5);
        tick();
        apply_stimulus(6'b000000, 1'b1, 5'd5, 5'd3);
        #1;
        check_output("lu_stall_ctl", {bus.pc_write, bus.ifid_write, bus.ifid_flush}, 3'b000);
        tick();
        check_output("lu_bubble_ex", {bus.ex_reg_dst, bus.ex_alu_src, bus.ex_alu_op}, 5'b0);
        check_output("lu_lw_mem", bus.mem_read, 1'b1);
        check_output("lu_release", {bus.pc_write, bus.ifid_write}, 2'b11);
        tick();
        check_output("lu_rtype_ex", {bus.ex_reg_dst, bus.ex_alu_src, bus.ex_alu_op}, 5'b1_0_101);
        check_output("lu_rtype_rt", bus.ex_rt, 5'd3);
        drain();

        // LW to $zero never stalls.
        apply_stimulus(6'b100011, 1'b1, 5'd1, 5'd0);
        tick();
        apply_stimulus(6'b000000, 1'b1, 5'd0, 5'd0);
        #1;
        check_output("zero_no_stall", {bus.pc_write, bus.ifid_write}, 2'b11);
        tick();
        check_output("zero_rtype_ex", {bus.ex_reg_dst, bus.ex_alu_op}, 4'b1_101);
        drain();

        // Branch taken in MEM flushes the two ADDIs behind it.
        apply_stimulus(6'b000100, 1'b1, 5'd1, 5'd2);
        tick();
        apply_stimulus(6'b001000, 1'b1, 5'd3, 5'd4);
        tick();
        apply_stimulus(6'b001000, 1'b1, 5'd5, 5'd6);
        bus.mem_branch_taken = 1'b1;
        #1;
        check_output("flush_ctl", {bus.pc_write, bus.ifid_write, bus.ifid_flush}, 3'b111);
        tick();
        bus.mem_branch_taken = 1'b0;
        apply_stimulus(6'b000000, 1'b0, 5'd0, 5'd0);
        check_output("flush_mem", {bus.mem_read, bus.mem_write, bus.mem_branch}, 3'b000);
        check_output("flush_ex", {bus.ex_alu_src, bus.ex_alu_op}, 4'b0);
        check_output("flush_beq_wb", bus.wb_reg_write, 1'b0);
        wb_hits = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.wb_reg_write) wb_hits++;
        end
        check_output("flush_addi_never_wb", wb_hits, 0);

        // Stall and flush in the same cycle: flush wins.
        apply_stimulus(6'b000100, 1'b1, 5'd1, 5'd2);
        tick();
        apply_stimulus(6'b100011, 1'b1, 5'd1, 5'd4);
        tick();
        apply_stimulus(6'b000000, 1'b1, 5'd4, 5'd0);
        bus.mem_branch_taken = 1'b1;
        #1;
        check_output("sf_ctl", {bus.pc_write, bus.ifid_write, bus.ifid_flush}, 3'b111);
        tick();
        bus.mem_branch_taken = 1'b0;
        apply_stimulus(6'b000000, 1'b0, 5'd0, 5'd0);
        check_output("sf_lw_killed", bus.mem_read, 1'b0);
        check_output("sf_ex_nop", {bus.ex_reg_dst, bus.ex_alu_op}, 4'b0);
        drain();

`ifdef UC_PIPE_ILLEGAL_TRAP_EN
        do_reset();
        check_output("ill_rst_cnt", bus.illegal_cnt, 8'd0);
        check_output("ill_rst_flag", bus.ex_illegal, 1'b0);
        wb_hits = 0;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(6'b111111, 1'b1, 5'd0, 5'd0);
            tick();
            if (bus.ex_illegal) wb_hits++;
        end
        apply_stimulus(6'b000000, 1'b0, 5'd0, 5'd0);
        tick();
        check_output("ill_pulses", wb_hits, 3);
        check_output("ill_cnt3", bus.illegal_cnt, 8'd3);
        check_output("ill_flag_low", bus.ex_illegal, 1'b0);
        apply_stimulus(6'b111111, 1'b1, 5'd0, 5'd0);
        repeat (300) tick();
        check_output("ill_sat", bus.illegal_cnt, 8'd255);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uc_pipe.md
Name: uc_pipe

Overview:
- Pipelined successor of the combinational MIPS control unit. It decodes the opcode in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Contains the load-use hazard detector, which stalls PC and IF/ID and inserts a bubble.
- Handles branch-taken flush.
- Sits between the IF/ID register and the datapath stage muxes; the datapath registers only data, never control.

Parameters:
ALUOP_W, 3, width of ALUOp field
RA_W, 5, register-address width for rs/rt hazard compare

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
id_op  in  6  opcode from IF/ID
id_valid  in  1  IF/ID holds a real instruction
id_rs  in  RA_W  rs field from IF/ID
id_rt  in  RA_W  rt field from IF/ID
mem_branch_taken  in  1  branch resolved taken in MEM (mem_branch & zero)
ex_reg_dst  out  1  EX stage RegDst
ex_alu_src  out  1  EX stage ALUSrc
ex_alu_op  out  ALUOP_W  EX stage ALUOp
ex_rt  out  RA_W  rt carried in ID/EX
mem_branch  out  1  MEM stage Branch
mem_read  out  1  MEM stage MemRead
mem_write  out  1  MEM stage MemWrite
wb_reg_write  out  1  WB stage RegWrite
wb_mem_to_reg  out  1  WB stage MemToReg
pc_write  out  1  PC enable (comb)
ifid_write  out  1  IF/ID enable (comb)
ifid_flush  out  1  clear IF/ID (comb)

Behaviour:
Decode table (comb, ID). Field order is RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp.
- 000000 R-type / 011100 MUL: 1,0,0,1,0,0,0,ALU_RTYPE(101)
- 100011 LW: 0,1,1,1,1,0,0,ALU_ADD(000)
- 101011 SW: 0,1,0,0,0,1,0,ALU_ADD
- 000100 BEQ: 0,0,0,0,0,0,1,ALU_SUB(001)
- 001000 ADDI: 0,1,0,1,0,0,0,ALU_ADD
- 001100 ANDI: 0,1,0,1,0,0,0,ALU_AND(010)
- 001101 ORI: 0,1,0,1,0,0,0,ALU_OR(011)
- 001010 SLTI: 0,1,0,1,0,0,0,ALU_SLT(100)
- Any other opcode, or id_valid=0: all-zero bundle (NOP). No X is ever driven.

Pipeline registers and latency:
- An instruction decoded at edge n drives its ex_* outputs after edge n, its mem_* outputs after n+1, and its wb_* outputs after n+2.

Hazard detection (comb):
- stall = mem_read_ex & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt) & id_valid
- mem_read_ex is the MemRead bit held in ID/EX.
- On stall: pc_write=0, ifid_write=0, and ID/EX loads the NOP bundle.
- A stall lasts exactly 1 cycle per load-use pair.

Branch flush:
- On mem_branch_taken: ifid_flush=1, ID/EX loads NOP, EX/MEM loads NOP.
- MEM/WB loads normally, so the branch itself retires.
- pc_write=1 and ifid_write=1.

Simultaneous events:
- flush overrides stall: pc_write=1 and stall is ignored that cycle.

Reset:
- All stage registers clear to NOP; ex_alu_op=0, ex_rt=0.
- Comb outputs pc_write=1, ifid_write=1, ifid_flush=0.
- rst mid-stream discards all in-flight control on the next edge, and rst has priority over stall and flush.

Optional Feature:
UC_PIPE_ILLEGAL_TRAP_EN
- Defined:
  - Adds output ex_illegal (1 bit). It is registered in ID/EX and is 1 when id_valid=1 and id_op is not in the table.
  - Adds output illegal_cnt (8 bit), which increments once per illegal instruction entering EX and saturates at 255.
  - Both are cleared by rst.
  - A flushed or stalled bubble never sets ex_illegal.
- Undefined: no ports, no logic. Illegal opcodes are silent NOPs.

Decomposition:
- Package uc_pkg holds:
  - opcode localparams (OP_RTYPE, OP_MUL, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI)
  - ALUOp codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_RTYPE)
  - packed struct ctrl_t {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op}
  - constant CTRL_NOP.
- One sub-module, uc_decode: purely combinational, op and valid in, ctrl_t out.
- Hazard logic and stage registers live in uc_pipe.

Test Plan:
- Reset: hold rst 2 cycles with id_op=LW and id_valid=1 → all outputs 0 and pc_write=1; first LW at ex_* appears 1 cycle after rst drops.
- Stream ADDI, LW, SW, BEQ, ORI with no hazards → at EX, MEM and WB, exactly 1, 2 and 3 cycles after each issue, the bundles match the decode table; ex_alu_op sequence is 000, 000, 000, 001, 011.
- LW with rt=5, then R-type with rs=5 → one cycle with pc_write=0, ifid_write=0 and a NOP bundle in EX; the R-type reaches EX one cycle later.
- LW with rt=0, then R-type with rs=0 → no stall.
- BEQ then two ADDIs, with mem_branch_taken=1 when the BEQ is in MEM → ifid_flush=1; the next cycle mem_read, mem_write and mem_branch are all 0; neither ADDI ever shows wb_reg_write=1; the BEQ reaches WB with wb_reg_write=0.
- Stall and flush in the same cycle → pc_write=1 and ifid_flush=1.
- With UC_PIPE_ILLEGAL_TRAP_EN: issue opcode 111111 three times → ex_illegal pulses 3 times and illegal_cnt=3.
- Feed 300 illegal opcodes → illegal_cnt saturates at 255.
